// File: rtl/bellmanford_main.sv
// Bellman-Ford accelerator: 8-node single-source shortest paths over byte arrays
// (weights, distances, predecessors, control) exposed through a 2-channel slave port.
module bellmanford_main #(
  parameter int unsigned MEM_var_28859_28868 = 64,   // DIST base
  parameter int unsigned MEM_var_28861_28868 = 128,  // PRED base
  parameter int unsigned MEM_var_28862_28866 = 256,  // W base
  parameter int unsigned MEM_var_28864_28868 = 192   // CTRL base
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  output logic        done_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [17:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  input  logic [15:0] M_Rdata_ram,
  input  logic [1:0]  M_DataRdy,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy,
  output logic [1:0]  Mout_oe_ram,
  output logic [1:0]  Mout_we_ram,
  output logic [17:0] Mout_addr_ram,
  output logic [15:0] Mout_Wdata_ram,
  output logic [7:0]  Mout_data_ram_size
);

  typedef enum logic [2:0] {StIdle, StInit, StRelax, StCheck, StDone} state_e;

  localparam logic [7:0] Inf = 8'hFF;

  state_e     state_q, state_d;
  logic [5:0] idx_q;
  logic [2:0] pass_q;
  logic [2:0] src_q;
  logic       changed_q;

  logic [7:0] w_mem    [64];
  logic [7:0] dist_mem [8];
  logic [7:0] pred_mem [8];
  logic [7:0] ctrl_mem [8];

  // Per-channel decode results
  logic [1:0] hit_w, hit_d, hit_p, hit_c, hit;
  logic [5:0] off_w [2];
  logic [5:0] off_d [2];
  logic [5:0] off_p [2];
  logic [5:0] off_c [2];
  logic [7:0] rbyte [2];
  logic [7:0] nbyte [2];

  // Relaxation datapath
  logic [2:0] u, v;
  logic [7:0] wt, du, dv, sat;
  logic [8:0] sum;
  logic       relax_en;

  // Master port is never used; its inputs are deliberately ignored.
  logic unused_master;
  assign unused_master = ^{M_Rdata_ram, M_DataRdy};

  assign Mout_oe_ram        = '0;
  assign Mout_we_ram        = '0;
  assign Mout_addr_ram      = '0;
  assign Mout_Wdata_ram     = '0;
  assign Mout_data_ram_size = '0;

  function automatic logic in_win(input logic [8:0] a, input int unsigned base);
    return (32'(a) >= base) && (32'(a) < base + 32'd64);
  endfunction

  function automatic logic [5:0] win_off(input logic [8:0] a, input int unsigned base);
    return 6'(32'(a) - base);
  endfunction

  // Slave address decode, current byte value and masked write value per channel
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      logic [8:0]  a;
      logic [15:0] m;
      logic [7:0]  wd;
      a  = S_addr_ram[ch*9 +: 9];
      wd = S_Wdata_ram[ch*8 +: 8];
      m  = (16'd1 << S_data_ram_size[ch*4 +: 4]) - 16'd1;
      hit_d[ch] = in_win(a, MEM_var_28859_28868);
      hit_p[ch] = in_win(a, MEM_var_28861_28868);
      hit_w[ch] = in_win(a, MEM_var_28862_28866);
      hit_c[ch] = in_win(a, MEM_var_28864_28868);
      off_d[ch] = win_off(a, MEM_var_28859_28868);
      off_p[ch] = win_off(a, MEM_var_28861_28868);
      off_w[ch] = win_off(a, MEM_var_28862_28866);
      off_c[ch] = win_off(a, MEM_var_28864_28868);
      hit[ch]   = hit_d[ch] | hit_p[ch] | hit_w[ch] | hit_c[ch];
      // Bytes past an array's defined size read as zero
      rbyte[ch] = 8'h00;
      if (hit_w[ch]) begin
        rbyte[ch] = w_mem[off_w[ch]];
      end else if (hit_d[ch]) begin
        if (off_d[ch][5:3] == 3'd0) rbyte[ch] = dist_mem[off_d[ch][2:0]];
      end else if (hit_p[ch]) begin
        if (off_p[ch][5:3] == 3'd0) rbyte[ch] = pred_mem[off_p[ch][2:0]];
      end else if (hit_c[ch]) begin
        if (off_c[ch][5:3] == 3'd0) rbyte[ch] = ctrl_mem[off_c[ch][2:0]];
      end
      nbyte[ch] = (wd & m[7:0]) | (rbyte[ch] & ~m[7:0]);
    end
  end

  // Edge (u,v) relaxation test for the current RELAX step
  always_comb begin
    u   = idx_q[5:3];
    v   = idx_q[2:0];
    wt  = w_mem[idx_q];
    du  = dist_mem[u];
    dv  = dist_mem[v];
    sum = {1'b0, du} + {1'b0, wt};
    sat = (sum > 9'd254) ? 8'hFE : sum[7:0];
    relax_en = (state_q == StRelax) && (u != v) && (wt != Inf) && (du != Inf) && (sat < dv);
  end

  // FSM next-state and done pulse
  always_comb begin
    state_d   = state_q;
    done_port = 1'b0;
    unique case (state_q)
      StIdle:  if (start_port) state_d = StInit;
      StInit:  if (idx_q == 6'd7) state_d = StRelax;
      StRelax: if (idx_q == 6'd63) state_d = StCheck;
      StCheck: state_d = (!changed_q || pass_q == 3'd6) ? StDone : StRelax;
      StDone: begin
        done_port = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register and loop counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pass_q    <= '0;
      src_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start_port) begin
            src_q     <= ctrl_mem[0][2:0];
            pass_q    <= '0;
            changed_q <= 1'b0;
            idx_q     <= '0;
          end
        end
        StInit: idx_q <= (idx_q == 6'd7) ? 6'd0 : idx_q + 6'd1;
        StRelax: begin
          idx_q <= idx_q + 6'd1;
          if (relax_en) changed_q <= 1'b1;
        end
        StCheck: begin
          pass_q    <= pass_q + 3'd1;
          changed_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Array storage: slave writes only while idle, otherwise the algorithm owns the arrays
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) w_mem[i] <= Inf;
      for (int i = 0; i < 8; i++) begin
        dist_mem[i] <= Inf;
        pred_mem[i] <= Inf;
        ctrl_mem[i] <= 8'h00;
      end
    end else begin
      if (state_q == StIdle) begin
        // Channel 1 wins when both channels write the same byte
        for (int ch = 0; ch < 2; ch++) begin
          if (S_we_ram[ch] && hit[ch]) begin
            if (hit_w[ch]) begin
              w_mem[off_w[ch]] <= nbyte[ch];
            end else if (hit_d[ch]) begin
              if (off_d[ch][5:3] == 3'd0) dist_mem[off_d[ch][2:0]] <= nbyte[ch];
            end else if (hit_p[ch]) begin
              if (off_p[ch][5:3] == 3'd0) pred_mem[off_p[ch][2:0]] <= nbyte[ch];
            end else if (hit_c[ch]) begin
              if (off_c[ch][5:3] == 3'd0) ctrl_mem[off_c[ch][2:0]] <= nbyte[ch];
            end
          end
        end
      end
      unique case (state_q)
        StInit: begin
          dist_mem[idx_q[2:0]] <= (idx_q[2:0] == src_q) ? 8'h00 : Inf;
          pred_mem[idx_q[2:0]] <= Inf;
        end
        StRelax: begin
          if (relax_en) begin
            dist_mem[v] <= sat;
            pred_mem[v] <= {5'd0, u};
          end
        end
        StDone: ctrl_mem[1] <= {5'd0, pass_q};
        default: ;
      endcase
    end
  end

  // Slave response: acknowledge any hit next cycle, return data only for pure reads
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Sout_Rdata_ram <= '0;
      Sout_DataRdy   <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        Sout_DataRdy[ch] <= hit[ch] && (S_oe_ram[ch] || S_we_ram[ch]);
        Sout_Rdata_ram[ch*8 +: 8] <= (hit[ch] && S_oe_ram[ch] && !S_we_ram[ch]) ?
                                     rbyte[ch] : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_bellmanford_main.sv
// Directed and randomized bench for bellmanford_main with a behavioural shortest-path model.
module tb_bellmanford_main;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_port;
  logic        done_port;
  logic [1:0]  S_oe_ram, S_we_ram;
  logic [17:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic [15:0] M_Rdata_ram;
  logic [1:0]  M_DataRdy;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;
  logic [1:0]  Mout_oe_ram, Mout_we_ram;
  logic [17:0] Mout_addr_ram;
  logic [15:0] Mout_Wdata_ram;
  logic [7:0]  Mout_data_ram_size;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [7:0] mw    [64];
  logic [7:0] mdist [8];
  logic [7:0] mpred [8];
  logic [7:0] mctrl [8];
  int         mpasses;

  bellmanford_main dut (
    .clock              (clock),
    .reset              (reset),
    .start_port         (start_port),
    .done_port          (done_port),
    .S_oe_ram           (S_oe_ram),
    .S_we_ram           (S_we_ram),
    .S_addr_ram         (S_addr_ram),
    .S_Wdata_ram        (S_Wdata_ram),
    .S_data_ram_size    (S_data_ram_size),
    .M_Rdata_ram        (M_Rdata_ram),
    .M_DataRdy          (M_DataRdy),
    .Sout_Rdata_ram     (Sout_Rdata_ram),
    .Sout_DataRdy       (Sout_DataRdy),
    .Mout_oe_ram        (Mout_oe_ram),
    .Mout_we_ram        (Mout_we_ram),
    .Mout_addr_ram      (Mout_addr_ram),
    .Mout_Wdata_ram     (Mout_Wdata_ram),
    .Mout_data_ram_size (Mout_data_ram_size)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One slave cycle on both channels; response sampled one cycle later
  task automatic acc(input logic [1:0] oe, input logic [1:0] we,
                     input logic [8:0] a0, input logic [8:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic [3:0] s0, input logic [3:0] s1,
                     output logic [15:0] rd, output logic [1:0] rdy);
    @(negedge clock);
    S_oe_ram = oe; S_we_ram = we; S_addr_ram = {a1, a0};
    S_Wdata_ram = {d1, d0}; S_data_ram_size = {s1, s0};
    @(negedge clock);
    rd = Sout_Rdata_ram; rdy = Sout_DataRdy;
    S_oe_ram = '0; S_we_ram = '0;
  endtask

  task automatic wr(input int ch, input logic [8:0] a, input logic [7:0] d, input logic [3:0] s,
                    output logic ack);
    logic [15:0] rd;
    logic [1:0]  rdy;
    if (ch == 0) acc(2'b00, 2'b01, a, 9'd0, d, 8'd0, s, 4'd8, rd, rdy);
    else         acc(2'b00, 2'b10, 9'd0, a, 8'd0, d, 4'd8, s, rd, rdy);
    ack = rdy[ch];
  endtask

  task automatic rd_chk(input string tag, input int ch, input logic [8:0] a,
                        input logic [7:0] exp);
    logic [15:0] rd;
    logic [1:0]  rdy;
    if (ch == 0) acc(2'b01, 2'b00, a, 9'd0, 8'd0, 8'd0, 4'd8, 4'd8, rd, rdy);
    else         acc(2'b10, 2'b00, 9'd0, a, 8'd0, 8'd0, 4'd8, 4'd8, rd, rdy);
    check(tag, {7'd0, rdy[ch], rd[ch*8 +: 8]}, {7'd0, 1'b1, exp});
  endtask

  // Shortest paths straight from the algorithm's rules
  function automatic void model_run();
    int s, sum;
    bit ch;
    s = int'(mctrl[0][2:0]);
    for (int i = 0; i < 8; i++) begin
      mdist[i] = (i == s) ? 8'h00 : 8'hFF;
      mpred[i] = 8'hFF;
    end
    mpasses = 0;
    do begin
      ch = 0;
      for (int uu = 0; uu < 8; uu++)
        for (int vv = 0; vv < 8; vv++)
          if (uu != vv && mw[uu*8+vv] != 8'hFF && mdist[uu] != 8'hFF) begin
            sum = int'(mdist[uu]) + int'(mw[uu*8+vv]);
            if (sum > 254) sum = 254;
            if (sum < int'(mdist[vv])) begin
              mdist[vv] = 8'(sum);
              mpred[vv] = 8'(uu);
              ch = 1;
            end
          end
      mpasses++;
    end while (ch && mpasses < 7);
    mctrl[1] = 8'(mpasses);
  endfunction

  function automatic void clear_graph();
    for (int i = 0; i < 64; i++) mw[i] = 8'hFF;
  endfunction

  task automatic load_graph();
    logic [15:0] rd;
    logic [1:0]  rdy;
    logic        ack;
    for (int i = 0; i < 32; i++)
      acc(2'b00, 2'b11, 9'(256 + 2*i), 9'(257 + 2*i), mw[2*i], mw[2*i+1], 4'd8, 4'd8, rd, rdy);
    wr(0, 9'd192, mctrl[0], 4'd8, ack);
  endtask

  // Start a run, measure cycles to done; optionally poke start and W mid-relax
  task automatic run_start(input string tag, input bit inject, input int exp_cycles);
    int cyc;
    bit got;
    @(negedge clock);
    start_port = 1'b1;
    cyc = 0; got = 0;
    while (!got && cyc < 2000) begin
      @(posedge clock); #1;
      cyc++;
      start_port = 1'b0;
      if (inject && cyc == 20) begin
        start_port = 1'b1;
        S_we_ram = 2'b01; S_addr_ram = {9'd0, 9'd257}; S_Wdata_ram = 16'h0011;
        S_data_ram_size = 8'h88;
      end
      if (inject && cyc == 21) begin
        check({tag, "_busy_write_ack"}, {15'd0, Sout_DataRdy[0]}, 16'd1);
        S_we_ram = 2'b00;
      end
      if (done_port) got = 1;
    end
    check({tag, "_latency"}, 16'(cyc), 16'(exp_cycles));
    @(posedge clock); #1;
    check({tag, "_done_one_cycle"}, {15'd0, done_port}, 16'd0);
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_chk($sformatf("%s_dist%0d", tag, i), 0, 9'(64 + i), mdist[i]);
      rd_chk($sformatf("%s_pred%0d", tag, i), 1, 9'(128 + i), mpred[i]);
    end
    rd_chk({tag, "_passes"}, 0, 9'd193, mctrl[1]);
  endtask

  task automatic do_graph(input string tag, input bit inject);
    load_graph();
    model_run();
    run_start(tag, inject, 9 + 65 * mpasses);
    check_results(tag);
  endtask

  initial begin
    logic [15:0] rd;
    logic [1:0]  rdy;
    logic        ack;
    logic [7:0]  d;
    logic [3:0]  s;
    logic [15:0] m;
    int          dones;

    reset = 1'b1; start_port = 1'b0;
    S_oe_ram = '0; S_we_ram = '0; S_addr_ram = '0; S_Wdata_ram = '0; S_data_ram_size = '0;
    M_Rdata_ram = 16'hA5A5; M_DataRdy = 2'b11;
    clear_graph();
    for (int i = 0; i < 8; i++) begin
      mdist[i] = 8'hFF; mpred[i] = 8'hFF; mctrl[i] = 8'h00;
    end
    repeat (3) @(negedge clock);
    check("reset_done", {15'd0, done_port}, 16'd0);
    check("reset_sout", {Sout_DataRdy, Sout_Rdata_ram[13:0]}, 16'd0);
    check("reset_mout", {Mout_oe_ram, Mout_we_ram, Mout_data_ram_size, 4'd0}, 16'd0);
    reset = 1'b0;

    // Reset contents and address decode
    rd_chk("reset_dist0", 0, 9'd64, 8'hFF);
    acc(2'b01, 2'b00, 9'd0, 9'd0, 8'd0, 8'd0, 4'd8, 4'd8, rd, rdy);
    check("miss_addr0", {rdy, rd[7:0]}, 10'd0);
    rd_chk("reset_w0", 1, 9'd256, 8'hFF);
    rd_chk("reset_pred7", 0, 9'd135, 8'hFF);
    rd_chk("reset_ctrl0", 1, 9'd192, 8'h00);
    acc(2'b00, 2'b00, 9'd64, 9'd64, 8'd0, 8'd0, 4'd8, 4'd8, rd, rdy);
    check("idle_no_ack", {14'd0, rdy}, 16'd0);

    // Writes beyond defined array size are dropped, reads give zero
    wr(0, 9'd72, 8'h55, 4'd8, ack);
    check("pad_write_ack", {15'd0, ack}, 16'd1);
    rd_chk("pad_read", 1, 9'd72, 8'h00);

    // oe+we together is a write
    acc(2'b01, 2'b01, 9'd195, 9'd0, 8'h5A, 8'd0, 4'd8, 4'd8, rd, rdy);
    check("oe_we_ack", {15'd0, rdy[0]}, 16'd1);
    mctrl[3] = 8'h5A;
    rd_chk("oe_we_read", 0, 9'd195, mctrl[3]);

    // Partial-width writes
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom_range(0, 255));
      s = (k == 0) ? 4'd8 : 4'($urandom_range(0, 9));
      wr(k % 2, 9'd194, d, s, ack);
      m = (16'd1 << s) - 16'd1;
      mctrl[2] = (d & m[7:0]) | (mctrl[2] & ~m[7:0]);
      rd_chk($sformatf("mask_write%0d", k), (k + 1) % 2, 9'd194, mctrl[2]);
    end

    // No edges, source 0
    clear_graph(); mctrl[0] = 8'h00;
    do_graph("no_edges", 1'b0);

    // Both channels read in the same cycle
    acc(2'b11, 2'b00, 9'd64, 9'd65, 8'd0, 8'd0, 4'd8, 4'd8, rd, rdy);
    check("dual_read", {rdy, rd[13:0]}, {2'b11, 6'h3F, 8'h00});
    check("dual_read_hi", {8'd0, rd[15:8]}, {8'd0, mdist[1]});

    // Chain with shortcut; busy-time start pulse and W write are ignored
    clear_graph(); mw[1] = 8'd3; mw[8 + 2] = 8'd4; mw[2] = 8'd10; mctrl[0] = 8'h00;
    do_graph("chain", 1'b1);
    rd_chk("chain_w01_kept", 1, 9'd257, mw[1]);

    // Saturating distances
    clear_graph(); mw[1] = 8'd200; mw[8 + 2] = 8'd200;
    do_graph("saturate", 1'b0);

    // Random graphs
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 64; i++)
        mw[i] = ($urandom_range(0, 99) < 30) ? 8'($urandom_range(0, 150)) : 8'hFF;
      mctrl[0] = 8'($urandom_range(0, 255));
      do_graph($sformatf("rand%0d", g), 1'b0);
    end

    // Reset in the middle of relaxation
    clear_graph(); mw[1] = 8'd3; mctrl[0] = 8'h03;
    load_graph();
    @(negedge clock); start_port = 1'b1;
    @(negedge clock); start_port = 1'b0;
    repeat (30) @(posedge clock);
    #1 reset = 1'b1;
    #1 check("abort_done_low", {15'd0, done_port}, 16'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clock); #1;
      if (done_port) dones++;
    end
    check("abort_no_done", 16'(dones), 16'd0);
    clear_graph();
    for (int i = 0; i < 8; i++) begin
      mdist[i] = 8'hFF; mpred[i] = 8'hFF; mctrl[i] = 8'h00;
    end
    check_results("abort");
    rd_chk("abort_ctrl0", 0, 9'd192, mctrl[0]);
    rd_chk("abort_w01", 1, 9'd257, mw[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
